// File: rtl/debounce_scan_pkg.sv
// Shared widths, FSM encoding and event record for the debouncer scan controller.
package debounce_scan_pkg;
   localparam int ADDR_W  = 3;
   localparam int DATA_W  = 8;
   localparam int MAX_DEV = 8;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SETTLE  = 3'd1;
   localparam logic [2:0] S_CAPTURE = 3'd2;
   localparam logic [2:0] S_REPORT  = 3'd3;
   localparam logic [2:0] S_GAP     = 3'd4;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [DATA_W-1:0] changed;
   } scan_ev_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/scan_state_table.sv
// Last-seen byte per device plus a primed flag; one write port, two async read ports.
module scan_state_table
   import debounce_scan_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] caddr,
   output logic [DATA_W-1:0] cdata,
   output logic              cvalid,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid
);
   logic [MAX_DEV-1:0][DATA_W-1:0] mem_q, mem_d;
   logic [MAX_DEV-1:0]             vld_q, vld_d;

   always_comb begin
      mem_d = mem_q;
      vld_d = vld_q;
      if (we) begin
         mem_d[waddr] = wdata;
         vld_d[waddr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '0;
         vld_q <= '0;
      end else begin
         mem_q <= mem_d;
         vld_q <= vld_d;
      end
   end

   assign cdata  = mem_q[caddr];
   assign cvalid = vld_q[caddr];
   assign rdata  = mem_q[raddr];
   assign rvalid = vld_q[raddr];
endmodule

// File: rtl/debounce_scan_ctrl.sv
// Round-robin poller for a bank of debouncers: select, settle, capture, and report
// bytes that differ from the last value seen for that device.
module debounce_scan_ctrl
   import debounce_scan_pkg::*;
#(
   parameter int NUM_DEV       = 8,
   parameter int SETTLE_CYCLES = 4,
   parameter int SCAN_GAP      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic [ADDR_W-1:0] aBus,
   input  logic [DATA_W-1:0] data_in,
   output logic              ev_valid,
   input  logic              ev_ready,
   output logic [ADDR_W-1:0] ev_addr,
   output logic [DATA_W-1:0] ev_data,
   output logic [DATA_W-1:0] ev_changed,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              sweep_done
);
   localparam int CNT_W = $clog2(max2(SETTLE_CYCLES, SCAN_GAP) + 1);
   localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'((SCAN_GAP > 0) ? SCAN_GAP - 1 : 0);
   localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_DEV - 1);
   localparam logic [ADDR_W:0]   NUM_DEV_L   = NUM_DEV[ADDR_W:0];

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] abus_q, abus_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ev_valid_q, ev_valid_d;
   scan_ev_t          ev_q, ev_d;
   logic              sweep_done_q, sweep_done_d;
   logic              advance;

   logic              tbl_we;
   logic [DATA_W-1:0] tbl_cdata, tbl_rdata;
   logic              tbl_cvalid, tbl_rvalid;

   scan_state_table u_table (
      .clk    (clk),
      .rst    (rst),
      .we     (tbl_we),
      .waddr  (idx_q),
      .wdata  (data_in),
      .caddr  (idx_q),
      .cdata  (tbl_cdata),
      .cvalid (tbl_cvalid),
      .raddr  (rd_addr),
      .rdata  (tbl_rdata),
      .rvalid (tbl_rvalid)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      ev_valid_d   = ev_valid_q;
      ev_d         = ev_q;
      sweep_done_d = 1'b0;
      tbl_we       = 1'b0;
      advance      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (en) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
            end
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = S_CAPTURE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_CAPTURE: begin
            // First visit after reset primes the entry silently.
            if (!tbl_cvalid) begin
               tbl_we  = 1'b1;
               advance = 1'b1;
            end else if (tbl_cdata != data_in) begin
               tbl_we        = 1'b1;
               ev_valid_d    = 1'b1;
               ev_d.addr     = idx_q;
               ev_d.data     = data_in;
               ev_d.changed  = data_in ^ tbl_cdata;
               state_d       = S_REPORT;
            end else begin
               advance = 1'b1;
            end
         end
         S_REPORT: begin
            if (ev_valid_q && ev_ready) begin
               ev_valid_d = 1'b0;
               advance    = 1'b1;
            end
         end
         S_GAP: begin
            if (!en) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == GAP_LAST) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (advance) begin
         cnt_d = '0;
         if (idx_q == LAST_IDX) begin
            idx_d        = '0;
            sweep_done_d = 1'b1;
            if (SCAN_GAP > 0) state_d = S_GAP;
            else              state_d = en ? S_SETTLE : S_IDLE;
         end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = en ? S_SETTLE : S_IDLE;
         end
      end

      // aBus follows idx only once a device is selected; it parks on the last one otherwise.
      abus_d = (state_d == S_SETTLE) ? idx_d : abus_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         abus_q       <= '0;
         cnt_q        <= '0;
         ev_valid_q   <= 1'b0;
         ev_q         <= '0;
         sweep_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         abus_q       <= abus_d;
         cnt_q        <= cnt_d;
         ev_valid_q   <= ev_valid_d;
         ev_q         <= ev_d;
         sweep_done_q <= sweep_done_d;
      end
   end

   assign aBus       = abus_q;
   assign ev_valid   = ev_valid_q;
   assign ev_addr    = ev_q.addr;
   assign ev_data    = ev_q.data;
   assign ev_changed = ev_q.changed;
   assign busy       = (state_q != S_IDLE);
   assign sweep_done = sweep_done_q;
   assign rd_data    = (({1'b0, rd_addr} < NUM_DEV_L) && tbl_rvalid) ? tbl_rdata : '0;
endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Directed + randomized bench for debounce_scan_ctrl against a sweep-level reference model.
`timescale 1ns/1ps
module tb_debounce_scan_ctrl;
   localparam int SC = 4, GP = 16, ND = 8;

   typedef struct packed {
      logic [2:0] a;
      logic [7:0] d;
      logic [7:0] c;
   } ev_t;

   logic       clk = 1'b0, rst = 1'b1, en = 1'b0, ev_ready = 1'b1, en3 = 1'b0;
   logic [2:0] rd_addr = 3'd0;
   logic [2:0] aBus, ev_addr, aBus3, ev_addr3;
   logic [7:0] data_in, ev_data, ev_changed, rd_data;
   logic [7:0] data_in3, ev_data3, ev_changed3, rd_data3;
   logic       ev_valid, busy, sweep_done, ev_valid3, busy3, sweep_done3;

   logic [7:0] dev  [ND];
   logic [7:0] mtbl [ND];
   ev_t        expq [$];
   int         vecs = 0, errs = 0;

   always #10 clk = ~clk;

   // Device bank: each device presents its current byte when selected.
   assign data_in  = dev[aBus];
   assign data_in3 = dev[aBus3];

   debounce_scan_ctrl #(.NUM_DEV(ND), .SETTLE_CYCLES(SC), .SCAN_GAP(GP)) dut (
      .clk(clk), .rst(rst), .en(en), .aBus(aBus), .data_in(data_in),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_addr(ev_addr), .ev_data(ev_data),
      .ev_changed(ev_changed), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
      .sweep_done(sweep_done));

   debounce_scan_ctrl #(.NUM_DEV(3), .SETTLE_CYCLES(SC), .SCAN_GAP(0)) dut3 (
      .clk(clk), .rst(rst), .en(en3), .aBus(aBus3), .data_in(data_in3),
      .ev_valid(ev_valid3), .ev_ready(1'b1), .ev_addr(ev_addr3), .ev_data(ev_data3),
      .ev_changed(ev_changed3), .rd_addr(rd_addr), .rd_data(rd_data3), .busy(busy3),
      .sweep_done(sweep_done3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_table(input string tag, input logic zero);
      for (int i = 0; i < ND; i++) begin
         rd_addr = 3'(i);
         #1;
         chk(tag, rd_data, zero ? 8'h00 : mtbl[i]);
      end
   endtask

   // Expected events for the coming sweep: devices whose byte differs from what was last reported.
   task automatic plan_sweep();
      for (int i = 0; i < ND; i++) begin
         if (dev[i] !== mtbl[i]) begin
            expq.push_back('{a: 3'(i), d: dev[i], c: dev[i] ^ mtbl[i]});
            mtbl[i] = dev[i];
         end
      end
   endtask

   task automatic run_sweep(input bit rnd_ready);
      int  n = 0, obs_cnt = 0, planned;
      bit  done = 0;
      ev_t e;
      planned = expq.size();
      while (!done && n < 3000) begin
         ev_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (ev_valid && ev_ready) begin
            obs_cnt++;
            if (expq.size() > 0) begin
               e = expq.pop_front();
               chk("ev_record", {ev_addr, ev_data, ev_changed}, {e.a, e.d, e.c});
            end
         end
         tick();
         n++;
         done = sweep_done;
      end
      ev_ready = 1'b1;
      chk("sweep_done_seen", done, 1'b1);
      chk("event_count", obs_cnt, planned);
      expq.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired vecs=%0d", vecs);
      $fatal(1, "watchdog");
   end

   initial begin
      int         n;
      bit         seen;
      logic [2:0] prev;

      for (int i = 0; i < ND; i++) begin
         dev[i]  = 8'hAA;
         mtbl[i] = 8'hAA;
      end

      // Reset state
      rst = 1'b1; en = 1'b0; ev_ready = 1'b1;
      tick(); tick();
      chk("rst_state", {aBus, ev_valid, busy, sweep_done}, 6'b0);
      chk_table("rst_table", 1'b1);

      // Priming sweep: all AA, no events, sweep takes NUM_DEV*(SETTLE+1) cycles
      rst = 1'b0; en = 1'b1;
      tick();
      chk("busy_start", busy, 1'b1);
      n = 0; seen = 0;
      while (!sweep_done && n < 200) begin
         tick(); n++;
         if (ev_valid) seen = 1;
      end
      chk("prime_cycles", n, ND * (SC + 1));
      chk("prime_no_event", seen, 1'b0);
      chk_table("prime_table", 1'b0);

      // Change on device 3 in the second sweep, held off by backpressure
      dev[3] = 8'hAB; mtbl[3] = 8'hAB;
      ev_ready = 1'b0; rd_addr = 3'd3;
      n = 0; prev = aBus;
      while (!ev_valid && n < 200) begin
         prev = aBus;
         tick(); n++;
      end
      chk("ev_latency", n, GP + (SC + 1) * 4);
      chk("capture_abus", prev, 3'd3);
      chk("ev_fields", {ev_addr, ev_data, ev_changed}, {3'd3, 8'hAB, 8'h01});
      chk("rd_after_write", rd_data, 8'hAB);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("bp_hold", {aBus, ev_valid, ev_addr, ev_data, ev_changed},
             {3'd3, 1'b1, 3'd3, 8'hAB, 8'h01});
      end
      ev_ready = 1'b1;
      tick();
      chk("post_hs", {ev_valid, aBus, busy}, {1'b0, 3'd4, 1'b1});
      run_sweep(1'b0);

      // Randomized sweeps with random backpressure
      for (int s = 0; s < 5; s++) begin
         for (int i = 0; i < ND; i++)
            if ($urandom_range(0, 1) == 1) dev[i] = 8'($urandom);
         plan_sweep();
         run_sweep(1'b1);
         chk_table("rand_table", 1'b0);
      end

      // en dropped while device 5 settles, with a pending change on device 5
      ev_ready = 1'b1;
      n = 0;
      while (aBus != 3'd5 && n < 300) begin
         tick(); n++;
      end
      chk("reach_dev5", aBus, 3'd5);
      en = 1'b0;
      dev[5] = mtbl[5] ^ 8'h3C;
      n = 0; seen = 0;
      while (busy && n < 50) begin
         tick(); n++;
         if (ev_valid) begin
            seen = 1;
            chk("ev5_fields", {ev_addr, ev_data, ev_changed}, {3'd5, dev[5], 8'h3C});
         end
      end
      mtbl[5] = dev[5];
      chk("ev5_seen", seen, 1'b1);
      chk("idle_latency", n, SC + 2);
      chk("idle_state", {busy, aBus}, {1'b0, 3'd5});
      tick(); tick(); tick();
      chk("idle_hold", {busy, aBus}, {1'b0, 3'd5});
      en = 1'b1;
      tick();
      chk("resume", {busy, aBus}, {1'b1, 3'd6});
      run_sweep(1'b0);

      // Reset during REPORT discards the event and clears the table
      dev[2] = mtbl[2] ^ 8'h81;
      ev_ready = 1'b0;
      n = 0;
      while (!ev_valid && n < 200) begin
         tick(); n++;
      end
      chk("rpt_ev_addr", {ev_valid, ev_addr}, {1'b1, 3'd2});
      rst = 1'b1;
      tick();
      rst = 1'b0; ev_ready = 1'b1;
      chk("rst_in_report", {ev_valid, busy, aBus, sweep_done, ev_addr, ev_data, ev_changed}, 25'b0);
      chk_table("rst_rpt_table", 1'b1);
      for (int i = 0; i < ND; i++) begin
         dev[i]  = 8'($urandom);
         mtbl[i] = dev[i];
      end
      run_sweep(1'b1);
      chk_table("reprime_table", 1'b0);

      // Three-device instance, back-to-back sweeps
      en3 = 1'b1;
      tick();
      chk("nd3_start", {busy3, aBus3}, {1'b1, 3'd0});
      for (int d = 1; d <= 3; d++) begin
         repeat (SC + 1) tick();
         chk("nd3_seq", {sweep_done3, aBus3}, {(d == 3), 3'(d % 3)});
      end
      rd_addr = 3'd1; #1;
      chk("nd3_rd_in", rd_data3, dev[1]);
      rd_addr = 3'd5; #1;
      chk("nd3_rd_out", rd_data3, 8'h00);
      chk("nd3_no_event", ev_valid3, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
